// File: rtl/soc_mem_arbiter_pkg.sv
// Shared types and constants for the two-master SoC memory bus arbiter.
// Imported by the bus interface, the arbiter and its testbench.
package soc_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef logic master_id_t;

   localparam master_id_t MASTER_IMEM = 1'b0;
   localparam master_id_t MASTER_DMEM = 1'b1;

   localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_mem_arbiter_if.sv
// Request/response memory bus: the Master drives the request, the Slave answers with a one-cycle valid.
interface SoC_MemBus;
   import soc_arb_pkg::*;

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic              write_en;
   logic [BE_W-1:0]   byte_en;
   logic              valid;
   logic [DATA_W-1:0] read_data;

   modport Master (
      output req, addr, write_data, write_en, byte_en,
      input  valid, read_data
   );

   modport Slave (
      input  req, addr, write_data, write_en, byte_en,
      output valid, read_data
   );

endinterface

// File: rtl/soc_mem_arbiter.sv
// Round-robin arbiter giving instruction fetch (imem) and data (dmem) access to one memory port.
// The winning request is latched for the slave, and a watchdog ends transactions the slave never answers.
module soc_mem_arbiter
   import soc_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
   input  logic       clk,
   input  logic       rst,
   SoC_MemBus.Slave   imem,
   SoC_MemBus.Slave   dmem,
   SoC_MemBus.Master  mem,
   output master_id_t grant_id,
   output logic       busy,
   output logic       bus_error
);

   localparam int WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t        state;
   master_id_t        owner;
   master_id_t        last_grant;
   logic [WD_W-1:0]   wd_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [BE_W-1:0]   be_q;

   logic              in_busy;
   logic              any_req;
   master_id_t        winner;
   logic              done;
   logic              timed_out;
   logic              finish;
   logic [DATA_W-1:0] resp_data;
   logic              imem_hit;
   logic              dmem_hit;

   assign in_busy = (state == ARB_BUSY);
   assign any_req = imem.req | dmem.req;

   // On a conflict the master that did not win last time goes first.
   assign winner = (imem.req && dmem.req) ? ~last_grant : master_id_t'(dmem.req);

   // A reset cycle suppresses completion so an aborted transaction is silently lost.
   assign done      = in_busy && mem.valid && !rst;
   assign timed_out = (TIMEOUT_CYCLES != 0) && in_busy && !mem.valid && !rst && (wd_cnt == WD_LAST);
   assign finish    = done | timed_out;
   assign resp_data = done ? mem.read_data : ERR_DATA;

   assign imem_hit = finish && (owner == MASTER_IMEM);
   assign dmem_hit = finish && (owner == MASTER_DMEM);

   assign imem.valid     = imem_hit;
   assign imem.read_data = imem_hit ? resp_data : '0;
   assign dmem.valid     = dmem_hit;
   assign dmem.read_data = dmem_hit ? resp_data : '0;

   assign mem.req        = in_busy;
   assign mem.addr       = addr_q;
   assign mem.write_data = wdata_q;
   assign mem.write_en   = we_q;
   assign mem.byte_en    = be_q;

   assign grant_id  = last_grant;
   assign busy      = in_busy;
   assign bus_error = timed_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         owner      <= MASTER_IMEM;
         last_grant <= MASTER_DMEM;
         wd_cnt     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         be_q       <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  state      <= ARB_BUSY;
                  owner      <= winner;
                  last_grant <= winner;
                  wd_cnt     <= '0;
                  if (winner == MASTER_DMEM) begin
                     addr_q  <= dmem.addr;
                     wdata_q <= dmem.write_data;
                     we_q    <= dmem.write_en;
                     be_q    <= dmem.byte_en;
                  end else begin
                     addr_q  <= imem.addr;
                     wdata_q <= imem.write_data;
                     we_q    <= imem.write_en;
                     be_q    <= imem.byte_en;
                  end
               end
            end
            ARB_BUSY: begin
               if (finish) begin
                  state <= ARB_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Self-checking bench for soc_mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_soc_mem_arbiter;
   import soc_arb_pkg::*;

   localparam int          TO      = 8;
   localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

   typedef struct {
      bit          rst;
      bit          ireq;
      logic [31:0] iaddr;
      logic [31:0] iwdata;
      bit          iwe;
      logic [3:0]  ibe;
      bit          dreq;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      bit          dwe;
      logic [3:0]  dbe;
      bit          mvalid;
      logic [31:0] mrdata;
   } stim_t;

   typedef struct {
      bit          mreq;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      bit          mwe;
      logic [3:0]  mbe;
      bit          ivalid;
      logic [31:0] irdata;
      bit          dvalid;
      logic [31:0] drdata;
      bit          gid;
      bit          busy;
      bit          berr;
   } resp_t;

   typedef struct {
      stim_t s;
      resp_t e;
      bit    chk_bus;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   master_id_t grant_id;
   logic       busy;
   logic       bus_error;

   SoC_MemBus imem_bus();
   SoC_MemBus dmem_bus();
   SoC_MemBus mem_bus();

   soc_mem_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .ERR_DATA(ERR_VAL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem(imem_bus),
      .dmem(dmem_bus),
      .mem(mem_bus),
      .grant_id(grant_id),
      .busy(busy),
      .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t mk_stim(bit r, bit ir, logic [31:0] ia, bit dr, logic [31:0] da,
                                     logic [31:0] dw, bit dwe, logic [3:0] dbe, bit mv, logic [31:0] md);
      stim_t s;
      s = idle_stim();
      s.rst = r;  s.ireq = ir; s.iaddr = ia; s.ibe = 4'hF;
      s.dreq = dr; s.daddr = da; s.dwdata = dw; s.dwe = dwe; s.dbe = dbe;
      s.mvalid = mv; s.mrdata = md;
      return s;
   endfunction

   function automatic resp_t mk_resp(bit mreq, logic [31:0] maddr, logic [31:0] mwdata, bit mwe,
                                     logic [3:0] mbe, bit iv, logic [31:0] ird, bit dv,
                                     logic [31:0] drd, bit gid, bit bsy, bit berr);
      resp_t e;
      e.mreq = mreq; e.maddr = maddr; e.mwdata = mwdata; e.mwe = mwe; e.mbe = mbe;
      e.ivalid = iv; e.irdata = ird; e.dvalid = dv; e.drdata = drd;
      e.gid = gid; e.busy = bsy; e.berr = berr;
      return e;
   endfunction

   task automatic apply_stimulus(stim_t s);
      rst                 = s.rst;
      imem_bus.req        = s.ireq;
      imem_bus.addr       = s.iaddr;
      imem_bus.write_data = s.iwdata;
      imem_bus.write_en   = s.iwe;
      imem_bus.byte_en    = s.ibe;
      dmem_bus.req        = s.dreq;
      dmem_bus.addr       = s.daddr;
      dmem_bus.write_data = s.dwdata;
      dmem_bus.write_en   = s.dwe;
      dmem_bus.byte_en    = s.dbe;
      mem_bus.valid       = s.mvalid;
      mem_bus.read_data   = s.mrdata;
   endtask

   task automatic check_output(resp_t e, bit chk_bus, string tag);
      check({tag, ".mem_req"},   32'(mem_bus.req),         32'(e.mreq));
      if (chk_bus) begin
         check({tag, ".mem_addr"},  mem_bus.addr,          e.maddr);
         check({tag, ".mem_wdata"}, mem_bus.write_data,    e.mwdata);
         check({tag, ".mem_we"},    32'(mem_bus.write_en), 32'(e.mwe));
         check({tag, ".mem_be"},    32'(mem_bus.byte_en),  32'(e.mbe));
      end
      check({tag, ".imem_valid"}, 32'(imem_bus.valid),    32'(e.ivalid));
      check({tag, ".imem_rdata"}, imem_bus.read_data,     e.irdata);
      check({tag, ".dmem_valid"}, 32'(dmem_bus.valid),    32'(e.dvalid));
      check({tag, ".dmem_rdata"}, dmem_bus.read_data,     e.drdata);
      check({tag, ".grant_id"},   32'(grant_id),          32'(e.gid));
      check({tag, ".busy"},       32'(busy),              32'(e.busy));
      check({tag, ".bus_error"},  32'(bus_error),         32'(e.berr));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Fairness: both masters hold req; the slave answers in the first cycle of every grant.
   task automatic run_fairness();
      stim_t s;
      int    grants;
      s = idle_stim();
      s.ireq = 1'b1; s.iaddr = 32'h300; s.ibe = 4'hF;
      s.dreq = 1'b1; s.daddr = 32'h400; s.dbe = 4'hF;
      grants = 0;
      for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
         s.mvalid = mem_bus.req;
         s.mrdata = 32'h1000 + cyc;
         apply_stimulus(s);
         @(negedge clk);
         if (mem_bus.req) begin
            check($sformatf("fair_grant%0d", grants), 32'(grant_id), 32'(grants % 2));
            grants++;
         end
         next_cycle();
      end
      check("fair_count", grants, 6);
      apply_stimulus(idle_stim());
      next_cycle();
   endtask

   task automatic run_latch();
      stim_t s;
      s = idle_stim();
      s.ireq = 1'b1; s.iaddr = 32'h40; s.ibe = 4'hF;
      apply_stimulus(s);
      next_cycle();
      s.iaddr = 32'h44;
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(s);
         @(negedge clk);
         check("latch_addr", mem_bus.addr, 32'h40);
         check("latch_ivalid", 32'(imem_bus.valid), 32'd0);
         next_cycle();
      end
      s.mvalid = 1'b1; s.mrdata = 32'h0BAD_CAFE;
      apply_stimulus(s);
      @(negedge clk);
      check("latch_addr_done", mem_bus.addr, 32'h40);
      check("latch_ivalid_done", 32'(imem_bus.valid), 32'd1);
      check("latch_rdata_done", imem_bus.read_data, 32'h0BAD_CAFE);
      next_cycle();
      apply_stimulus(idle_stim());
      next_cycle();
   endtask

   task automatic run_timeout(bit answer_last);
      stim_t s;
      string tag;
      tag = answer_last ? "to_race" : "to_silent";
      s = idle_stim();
      s.dreq = 1'b1; s.daddr = 32'h80; s.dbe = 4'hF;
      apply_stimulus(s);
      @(negedge clk);
      check({tag, ".req0"}, 32'(mem_bus.req), 32'd0);
      next_cycle();
      for (int k = 1; k <= TO; k++) begin
         s.mvalid = answer_last && (k == TO);
         s.mrdata = 32'h600D_F00D;
         apply_stimulus(s);
         @(negedge clk);
         check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
         if (k < TO) begin
            check($sformatf("%s.dvalid%0d", tag, k), 32'(dmem_bus.valid), 32'd0);
            check($sformatf("%s.berr%0d", tag, k), 32'(bus_error), 32'd0);
         end else begin
            check({tag, ".dvalid_end"}, 32'(dmem_bus.valid), 32'd1);
            check({tag, ".rdata_end"}, dmem_bus.read_data, answer_last ? 32'h600D_F00D : ERR_VAL);
            check({tag, ".berr_end"}, 32'(bus_error), answer_last ? 32'd0 : 32'd1);
         end
         next_cycle();
      end
      apply_stimulus(idle_stim());
      @(negedge clk);
      check({tag, ".busy_after"}, 32'(busy), 32'd0);
      check({tag, ".berr_after"}, 32'(bus_error), 32'd0);
      next_cycle();
   endtask

   task automatic run_reset_mid_busy();
      stim_t s;
      s = idle_stim();
      s.ireq = 1'b1; s.iaddr = 32'h200; s.ibe = 4'hF;
      apply_stimulus(s);
      next_cycle();
      apply_stimulus(s);
      @(negedge clk);
      check("rstmid.busy", 32'(busy), 32'd1);
      next_cycle();
      s.rst = 1'b1; s.mvalid = 1'b1; s.mrdata = 32'h99;
      apply_stimulus(s);
      @(negedge clk);
      check("rstmid.ivalid_rst", 32'(imem_bus.valid), 32'd0);
      check("rstmid.berr_rst", 32'(bus_error), 32'd0);
      next_cycle();
      apply_stimulus(idle_stim());
      @(negedge clk);
      check_output(mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1, "rstmid.after");
      next_cycle();
   endtask

   // Reference model: one in-flight transaction record plus the last granted master.
   bit          m_active;
   master_id_t  m_owner;
   master_id_t  m_last;
   int          m_age;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   bit          m_we;
   logic [3:0]  m_be;

   task automatic model_reset();
      m_active = 1'b0; m_owner = MASTER_IMEM; m_last = MASTER_DMEM; m_age = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_be = '0;
   endtask

   task automatic run_random(int cycles);
      stim_t      s;
      resp_t      e;
      bit         done;
      bit         to;
      bit         w;
      logic [31:0] data;
      s = idle_stim();
      s.rst = 1'b1;
      apply_stimulus(s);
      next_cycle();
      model_reset();
      for (int c = 0; c < cycles; c++) begin
         s.rst    = ($urandom_range(0, 199) == 0);
         s.ireq   = ($urandom_range(0, 2) != 0);
         s.iaddr  = $urandom;
         s.iwdata = $urandom;
         s.iwe    = $urandom_range(0, 1);
         s.ibe    = 4'($urandom);
         s.dreq   = ($urandom_range(0, 2) != 0);
         s.daddr  = $urandom;
         s.dwdata = $urandom;
         s.dwe    = $urandom_range(0, 1);
         s.dbe    = 4'($urandom);
         s.mvalid = ($urandom_range(0, 3) == 0);
         s.mrdata = $urandom;

         done = m_active && !s.rst && s.mvalid;
         to   = m_active && !s.rst && !s.mvalid && (m_age == TO - 1);
         data = done ? s.mrdata : ERR_VAL;
         e.mreq = m_active; e.maddr = m_addr; e.mwdata = m_wdata; e.mwe = m_we; e.mbe = m_be;
         e.ivalid = (done || to) && (m_owner == MASTER_IMEM);
         e.dvalid = (done || to) && (m_owner == MASTER_DMEM);
         e.irdata = e.ivalid ? data : 32'd0;
         e.drdata = e.dvalid ? data : 32'd0;
         e.gid = m_last; e.busy = m_active; e.berr = to;

         apply_stimulus(s);
         @(negedge clk);
         check_output(e, 1'b1, "rand");

         if (s.rst) begin
            model_reset();
         end else if (m_active) begin
            if (done || to) m_active = 1'b0;
            else m_age++;
         end else if (s.ireq || s.dreq) begin
            w = (s.ireq && s.dreq) ? !m_last : s.dreq;
            m_active = 1'b1; m_owner = w; m_last = w; m_age = 0;
            m_addr  = w ? s.daddr  : s.iaddr;
            m_wdata = w ? s.dwdata : s.iwdata;
            m_we    = w ? s.dwe    : s.iwe;
            m_be    = w ? s.dbe    : s.ibe;
         end
         next_cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "[TB] aborted");
   end

   initial begin
      vec_t vecs[$];
      stim_t sw;
      sw = mk_stim(0, 1, 32'h10, 1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 0, 0);

      vecs.push_back('{mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1});
      vecs.push_back('{mk_stim(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0});
      vecs.push_back('{mk_stim(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(1, 32'h100, 0, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(1, 32'h100, 0, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h1234_5678),
                       mk_resp(1, 32'h100, 0, 0, 4'hF, 1, 32'h1234_5678, 0, 0, 0, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0});
      vecs.push_back('{mk_stim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0});
      vecs.push_back('{sw, mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0});
      vecs.push_back('{sw, mk_resp(1, 32'h10, 0, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 1, 32'h10, 1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 1, 32'h1111_1111),
                       mk_resp(1, 32'h10, 0, 0, 4'hF, 1, 32'h1111_1111, 0, 0, 0, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 0, 0, 1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0});
      vecs.push_back('{mk_stim(0, 0, 0, 1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 0, 0),
                       mk_resp(1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 0, 0, 0, 0, 1, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 0, 0, 1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 1, 32'hCAFE_F00D),
                       mk_resp(1, 32'h20, 32'hA5A5_A5A5, 1, 4'b0011, 0, 0, 1, 32'hCAFE_F00D, 1, 1, 0), 1});
      vecs.push_back('{mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0});
      vecs.push_back('{mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0});

      $display("[TB] starting soc_mem_arbiter test, TIMEOUT_CYCLES=%0d", TO);
      sw = idle_stim();
      sw.rst = 1'b1;
      apply_stimulus(sw);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].s);
         @(negedge clk);
         check_output(vecs[i].e, vecs[i].chk_bus, $sformatf("vec%0d", i));
         next_cycle();
      end

      run_fairness();
      run_latch();
      run_timeout(1'b0);
      run_timeout(1'b1);
      run_reset_mid_busy();
      run_random(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_mem_arbiter.md
# soc_mem_arbiter

Two-master, one-slave arbiter for the SoC memory bus. Instruction fetch and data access share a single memory port. Masters attach as `SoC_MemBus.Slave` ports and the memory attaches as a `SoC_MemBus.Master` port. Conflicts are resolved round-robin, the granted request is latched so the slave sees stable signals, and a watchdog terminates transactions the slave never answers.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum BUSY cycles before forced termination; 0 disables the watchdog.
- `ERR_DATA`, default 32'hDEAD_BEEF: `read_data` returned on timeout.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem`  SoC_MemBus.Slave  -  master 0 (instruction fetch).
- `dmem`  SoC_MemBus.Slave  -  master 1 (data).
- `mem`  SoC_MemBus.Master  -  shared downstream memory.
- `grant_id`  out  1  owner of the current or last transaction (0 = imem, 1 = dmem).
- `busy`  out  1  high while in BUSY.
- `bus_error`  out  1  one-cycle pulse on timeout.

## Operation
- Bus protocol:
  - A master raises `req` with `addr`, `write_data`, `write_en` and `byte_en`, and holds `req` until it sees `valid`.
  - The slave answers with `valid` high for exactly one cycle, with `read_data` valid in that cycle.
  - A master keeping `req` high in the cycle after its `valid` counts as a new request.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - `mem.req` = 0.
  - If either master's `req` = 1, pick the winner and go to BUSY next cycle.
  - On the transition, latch the winner's `addr`, `write_data`, `write_en` and `byte_en` into registers, and set `owner` and `last_grant` to the winner.
- Winner selection:
  - Only one request: that master wins.
  - Both requesting: the master that is not `last_grant` wins.
- BUSY:
  - `mem.req` = 1; the `mem` address, data and control outputs are driven from the latched registers.
  - Changes on the owner's inputs are ignored until the transaction completes.
  - A non-owner's `req` stays pending.
- Completion:
  - In a BUSY cycle with `mem.valid` = 1: `owner.valid` = 1 and `owner.read_data` = `mem.read_data`, combinationally in the same cycle.
  - Next state is IDLE.
- Timeout (`TIMEOUT_CYCLES` != 0):
  - `wd_cnt` clears on entering BUSY and increments each BUSY cycle without `mem.valid`.
  - In the BUSY cycle where `wd_cnt` = `TIMEOUT_CYCLES`-1 and `mem.valid` = 0: `owner.valid` = 1, `owner.read_data` = `ERR_DATA`, `bus_error` = 1, next state IDLE.
  - `mem.valid` arriving in that same cycle takes precedence over the timeout: normal completion, no error.
- Non-owner outputs: `valid` = 0 and `read_data` = 0 at all times.
- `mem.valid` while IDLE is ignored.
- Slaves must not answer after `req` drops. A late answer after re-grant is a protocol violation and is not detected.
- `owner` drops `req` mid-transaction: the transaction still completes on `mem`, and `valid` is still pulsed to that master.

## Timing
- Reset values:
  - State IDLE, `last_grant` = 1 (so imem wins the first conflict), `owner` = 0, `wd_cnt` = 0, latched registers 0.
  - Outputs: `mem.req` = 0, all master `valid` = 0, `grant_id` = 1, `busy` = 0, `bus_error` = 0.
- Arbitration latency is 1 cycle: `req` sampled in cycle N gives `mem.req` = 1 in N+1.
- Completion is zero-latency from `mem.valid` to `owner.valid`.
- Minimum transaction is 2 cycles: N request, N+1 slave responds.
- Back-to-back: a pending request is re-granted in the IDLE cycle after completion, so `mem.req` is low for exactly one cycle between transactions.
- `rst` asserted mid-transaction: next cycle is IDLE with `mem.req` = 0 and no `valid` or `bus_error` emitted; the transaction is lost.
- Worst-case wait for a continuously requesting master is one foreign transaction plus 1 cycle.

## Structure
- Package `soc_arb_pkg` holds:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_BUSY`).
  - `master_id_t` (1-bit).
  - `DEFAULT_ERR_DATA` constant.
- `wd_cnt` width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit.
- No sub-module: the round-robin pick is a single combinational expression.

## Test plan
- Single imem read: `imem.req`=1 with addr 0x100 at cycle 0; slave valid at cycle 3 with data 0x12345678 → `mem.req`=1 in cycles 1–3 with addr 0x100; `imem.valid`=1 and `imem.read_data`=0x12345678 in cycle 3; `dmem.valid`=0 throughout.
- Simultaneous requests from reset: imem addr 0x10, dmem write addr 0x20/data 0xA5A5A5A5/`byte_en`=4'b0011 → imem is served first; dmem is granted in the cycle after imem's valid with exactly one idle cycle between; `mem.byte_en`=4'b0011 during the dmem transaction.
- Fairness: both masters request continuously for 6 transactions → `grant_id` sequence is 0,1,0,1,0,1.
- Latch stability: imem changes addr from 0x40 to 0x44 while BUSY → `mem.addr` stays 0x40 until valid.
- Timeout with `TIMEOUT_CYCLES`=8: dmem request, slave silent → `dmem.valid`=1, `read_data`=0xDEADBEEF and `bus_error`=1 in the 8th BUSY cycle; IDLE next cycle. Slave valid arriving exactly in the 8th BUSY cycle → normal data, no `bus_error`.
- Reset mid-BUSY → `mem.req`=0 next cycle, no `valid` to either master, `grant_id`=1.
